// File: rtl/srl16_fifo.sv
// srl16_fifo: first-word-fall-through FIFO, 16 deep, on SRL16E-style shift storage.
// Define SRL16_FIFO_OREG_EN to add a registered output stage (DOUT from a flop).
module srl16_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             EMPTY,
    output logic             FULL,
    output logic [4:0]       COUNT,
    output logic             OVF,
    output logic             UDF
);

    logic [15:0]      srl [WIDTH];
    logic [4:0]       cnt;
    logic [4:0]       cnt_nxt;
    logic [3:0]       ra;
    logic [WIDTH-1:0] tap;
    logic             full;
    logic             avail;
    logic             wr;
    logic             rd;
    logic             dec;

    assign full  = (cnt == 5'd16);
    assign avail = (cnt != 5'd0);
    assign ra    = cnt[3:0] - 4'd1;
    assign wr    = WR_EN & ~full;
    assign FULL  = full;

    // Shift new words in at tap 0; storage is never reset, like the primitive
    always_ff @(posedge CLK) begin
        if (wr & ~RST) begin
            for (int i = 0; i < WIDTH; i++) begin
                srl[i] <= {srl[i][14:0], DIN[i]};
            end
        end
    end

    // Oldest word sits at address cnt-1 in every bit register
    always_comb begin
        tap = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tap[i] = srl[i][ra];
        end
    end

`ifdef SRL16_FIFO_OREG_EN
    logic [WIDTH-1:0] oreg;
    logic             ov;
    logic             ld;

    assign rd  = RD_EN & ov;
    assign ld  = (~ov | rd) & avail;
    assign dec = ld;

    // Output stage refills from storage whenever it is empty or being popped
    always_ff @(posedge CLK) begin
        if (RST) begin
            oreg <= '0;
            ov   <= 1'b0;
        end else if (ld) begin
            oreg <= tap;
            ov   <= 1'b1;
        end else if (rd) begin
            ov   <= 1'b0;
        end
    end

    assign DOUT  = oreg;
    assign EMPTY = ~ov;
    assign COUNT = cnt + {4'd0, ov};
`else
    assign rd    = RD_EN & avail;
    assign dec   = rd;
    assign DOUT  = tap;
    assign EMPTY = ~avail;
    assign COUNT = cnt;
`endif

    // Occupancy moves only when exactly one of push/pull happens
    always_comb begin
        cnt_nxt = cnt;
        case ({wr, dec})
            2'b10:   cnt_nxt = cnt + 5'd1;
            2'b01:   cnt_nxt = cnt - 5'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Counter and registered overflow/underflow pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= 5'd0;
            OVF <= 1'b0;
            UDF <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            OVF <= WR_EN & full;
            UDF <= RD_EN & EMPTY;
        end
    end

endmodule
